// File: rtl/keyboard_scanner.sv
// keyboard_scanner: sequences the keyboard matrix for the system VIA.
// Auto-scan mode walks a free-running column counter and flags keys in rows 1..7 on CA2;
// manual mode lets the CPU address a row/column through port A and read the key on PA7.
// Optional feature macro: KBD_STICKY_IRQ_EN (CA2 held until IRQ_ACK).
module keyboard_scanner #(
    parameter int unsigned NUM_COLS = 10,
    parameter int unsigned SCAN_DIV = 2
) (
    input  logic       clk2MHz,
    input  logic       RESET,
    input  logic       KB_nEN,
    input  logic [6:0] PA_in,
    input  logic [7:0] KEY_ROW,
    input  logic       IRQ_ACK,
    output logic [3:0] KEY_COL,
    output logic       PA7_out,
    output logic       CA2
);

    localparam int unsigned DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0]  LastCol = 4'(NUM_COLS - 1);
    localparam logic [DivW-1:0] LastDiv = DivW'(SCAN_DIV - 1);

    typedef enum logic {
        StManual = 1'b0,
        StScan   = 1'b1
    } mode_e;

    mode_e           mode_q, mode_d;
    logic [3:0]      col_q, col_d;
    logic [DivW-1:0] div_q, div_d;
    logic            pa7_q, pa7_d;
    logic            ca2_q, ca2_d;
    logic            key_set;

`ifndef KBD_STICKY_IRQ_EN
    // Acknowledge has no effect when CA2 is a plain level.
    logic unused_irq_ack;
    assign unused_irq_ack = IRQ_ACK;
`endif

    // Column select: counter in scan mode, CPU column straight through in manual mode.
    always_comb begin
        KEY_COL = PA_in[3:0];
        if (mode_q == StScan) begin
            KEY_COL = col_q;
        end
    end

    // Next-state: mode follows KB_nEN; counter/divider advance only while scanning.
    always_comb begin
        mode_d  = KB_nEN ? StScan : StManual;
        col_d   = col_q;
        div_d   = div_q;
        pa7_d   = 1'b0;
        // Row 0 holds SHIFT/CTRL/links and must never interrupt.
        key_set = |KEY_ROW[7:1];
        unique case (mode_q)
            StScan: begin
                if (div_q == LastDiv) begin
                    div_d = '0;
                    col_d = (col_q == LastCol) ? 4'd0 : col_q + 4'd1;
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            StManual: begin
                pa7_d = KEY_ROW[PA_in[6:4]];
            end
            default: ;
        endcase
`ifdef KBD_STICKY_IRQ_EN
        // A new set wins over a simultaneous acknowledge.
        ca2_d = key_set | (ca2_q & ~IRQ_ACK);
`else
        ca2_d = key_set;
`endif
    end

    // State registers with synchronous reset that overrides everything.
    always_ff @(posedge clk2MHz) begin
        if (RESET) begin
            mode_q <= StManual;
            col_q  <= 4'd0;
            div_q  <= '0;
            pa7_q  <= 1'b0;
            ca2_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            col_q  <= col_d;
            div_q  <= div_d;
            pa7_q  <= pa7_d;
            ca2_q  <= ca2_d;
        end
    end

    assign PA7_out = pa7_q;
    assign CA2     = ca2_q;

endmodule

// File: tb/tb_keyboard_scanner.sv
// tb_keyboard_scanner: directed plus randomized stimulus against a behavioural model that
// tracks scan progress as a plain cycle count and a keyboard matrix as an array.
module tb_keyboard_scanner;

    localparam int unsigned NumCols = 10;
    localparam int unsigned ScanDiv = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       kb_nen;
    logic [6:0] pa_in;
    logic [7:0] key_row;
    logic       irq_ack;
    logic [3:0] key_col;
    logic       pa7_out;
    logic       ca2;

    // Keyboard matrix: one row byte per column; columns beyond NumCols read as zero.
    logic [7:0] matrix [16];

    always #5 clk = ~clk;

    assign key_row = matrix[key_col];

    keyboard_scanner #(
        .NUM_COLS(NumCols),
        .SCAN_DIV(ScanDiv)
    ) dut (
        .clk2MHz(clk),
        .RESET  (reset),
        .KB_nEN (kb_nen),
        .PA_in  (pa_in),
        .KEY_ROW(key_row),
        .IRQ_ACK(irq_ack),
        .KEY_COL(key_col),
        .PA7_out(pa7_out),
        .CA2    (ca2)
    );

    // Model state: scanning flag, elapsed scan cycles mod one full sweep, registered outputs.
    bit scan_m;
    int unsigned pos_m;
    logic pa7_m;
    logic ca2_m;
    int checks = 0;
    int fails  = 0;

    function automatic logic [3:0] model_col();
        if (scan_m) return 4'((pos_m / ScanDiv) % NumCols);
        return pa_in[3:0];
    endfunction

    // One clock: drive inputs, check the combinational column, clock, check registered outputs.
    task automatic step(input logic rst, input logic nen, input logic [6:0] pa, input logic ack);
        logic [3:0] col_e;
        logic [7:0] row_e;
        @(negedge clk);
        reset   = rst;
        kb_nen  = nen;
        pa_in   = pa;
        irq_ack = ack;
        #1;
        col_e = model_col();
        checks++;
        assert (key_col === col_e) else begin
            fails++;
            $error("FAIL key_col: got %0d want %0d", key_col, col_e);
        end
        row_e = matrix[col_e];
        @(posedge clk);
        if (rst) begin
            scan_m = 1'b0;
            pos_m  = 0;
            pa7_m  = 1'b0;
            ca2_m  = 1'b0;
        end else begin
`ifdef KBD_STICKY_IRQ_EN
            ca2_m = (|row_e[7:1]) | (ca2_m & ~ack);
`else
            ca2_m = |row_e[7:1];
`endif
            pa7_m = scan_m ? 1'b0 : row_e[pa[6:4]];
            if (scan_m) pos_m = (pos_m + 1) % (NumCols * ScanDiv);
            scan_m = nen;
        end
        #1;
        checks++;
        assert (pa7_out === pa7_m) else begin
            fails++;
            $error("FAIL pa7_out: got %b want %b", pa7_out, pa7_m);
        end
        checks++;
        assert (ca2 === ca2_m) else begin
            fails++;
            $error("FAIL ca2: got %b want %b", ca2, ca2_m);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) matrix[i] = 8'h00;
        reset   = 1'b1;
        kb_nen  = 1'b1;
        pa_in   = 7'h00;
        irq_ack = 1'b0;
        scan_m  = 1'b0;
        pos_m   = 0;
        pa7_m   = 1'b0;
        ca2_m   = 1'b0;

        // Reset for two clocks, then a full scan sweep and wrap.
        step(1'b1, 1'b1, 7'h00, 1'b0);
        step(1'b1, 1'b1, 7'h00, 1'b0);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 7'h00, 1'b0);

        // Key in row 4 of column 4 only.
        matrix[4] = 8'h10;
        for (int i = 0; i < 22; i++) step(1'b0, 1'b1, 7'h00, 1'b0);

        // Row 0 held on every column: never an interrupt.
        for (int i = 0; i < NumCols; i++) matrix[i] = 8'h01;
        for (int i = 0; i < 22; i++) step(1'b0, 1'b1, 7'h00, 1'b0);

        // Manual read of row 2, column 3, then row 3 of the same column.
        for (int i = 0; i < NumCols; i++) matrix[i] = 8'h00;
        matrix[3] = 8'h04;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 7'h23, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 7'h33, 1'b0);
        // Manual column outside the matrix passes through.
        step(1'b0, 1'b0, 7'h0c, 1'b0);
        step(1'b0, 1'b0, 7'h4f, 1'b0);

        // Scan to column 6 mid-dwell, pause in manual for 5 clocks, then resume.
        matrix[6] = 8'h80;
        while (!(scan_m && pos_m == 6 * ScanDiv)) step(1'b0, 1'b1, 7'h00, 1'b0);
        step(1'b0, 1'b0, 7'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 7'h16, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 7'h00, 1'b0);

        // Reset in the middle of a scan dwell.
        while (!(scan_m && pos_m == 7 * ScanDiv + 1)) step(1'b0, 1'b1, 7'h00, 1'b0);
        step(1'b1, 1'b1, 7'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 7'h00, 1'b0);

        // Randomized traffic: sparse matrix, mode flips, acks and occasional resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                for (int i = 0; i < NumCols; i++)
                    matrix[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            end
            if ($urandom_range(0, 19) == 0) kb_nen = ~kb_nen;
            step(($urandom_range(0, 99) == 0), kb_nen, 7'($urandom),
                 ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
